// File: rtl/sub_bytes_enc_seq_pkg.sv
// Shared AES definitions for the folded forward SubBytes engine:
// block/byte widths, FSM encoding and the GF(2^8) multiply used by the S-box.
package sub_bytes_enc_seq_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] aa;
        r  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

endpackage

// File: rtl/sub_bytes_enc_seq_s_box_enc.sv
// Combinational forward AES S-box: multiplicative inverse in GF(2^8)
// followed by the affine transform.
module S_Box_Enc
    import sub_bytes_enc_seq_pkg::*;
(
    input  logic [7:0] i_Din,
    output logic [7:0] o_Dout
);

    logic [7:0] inv;

    // x^254 = x^2 * x^4 * ... * x^128, which also maps 0 to 0.
    always_comb begin
        logic [7:0] p;
        p   = gf_mul(i_Din, i_Din);
        inv = p;
        for (int i = 0; i < 6; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
    end

    assign o_Dout = inv
                  ^ {inv[6:0], inv[7]}
                  ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/sub_bytes_enc_seq.sv
// Folded forward SubBytes: LANES S-boxes walk the 128-bit state over
// 16/LANES cycles, with valid/ready on both sides.
module sub_bytes_enc_seq
    import sub_bytes_enc_seq_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic [AES_BLOCK_W-1:0] i_Din,
    input  logic                   i_Valid,
    output logic                   o_Ready,
    output logic [AES_BLOCK_W-1:0] o_Dout,
    output logic                   o_Valid,
    input  logic                   i_Ready
);

    localparam int STEPS = 16 / LANES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    state_t                              state;
    logic [CNT_W-1:0]                    cnt;
    logic [AES_BLOCK_W-1:0]              work;
    logic [AES_BLOCK_W-1:0]              next_work;
    logic [LANES-1:0][AES_BYTE_W-1:0]    lane_in;
    logic [LANES-1:0][AES_BYTE_W-1:0]    lane_out;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_in[g] = work[(LANES * int'(cnt) + g) * AES_BYTE_W +: AES_BYTE_W];

        S_Box_Enc u_sbox (
            .i_Din  (lane_in[g]),
            .o_Dout (lane_out[g])
        );
    end

    always_comb begin
        next_work = work;
        for (int g = 0; g < LANES; g++)
            next_work[(LANES * int'(cnt) + g) * AES_BYTE_W +: AES_BYTE_W] = lane_out[g];
    end

    // DONE with downstream ready is an accept slot, giving back-to-back blocks.
    assign o_Ready = i_Rst_n && ((state == IDLE) || (state == DONE && i_Ready));

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            work    <= '0;
            o_Dout  <= '0;
            o_Valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_Valid) begin
                        work  <= i_Din;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    work <= next_work;
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        state   <= DONE;
                        o_Valid <= 1'b1;
                        o_Dout  <= next_work;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (i_Ready) begin
                        o_Valid <= 1'b0;
                        if (i_Valid) begin
                            work  <= i_Din;
                            cnt   <= '0;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
